// File: rtl/aes_top_pack.sv
// Shared constants for the AES block register map plus the MAC configuration
// master's state type.
package aes_top_pack;

  localparam int unsigned ADDRESS_SIZE   = 8;
  localparam int unsigned REG_SIZE       = 32;
  localparam int unsigned MAC_ADDR_WIDTH = 48;

  // Register slave addresses of the MAC address registers
  localparam logic [ADDRESS_SIZE-1:0] SOURCE_MAC_ADDR_1 = ADDRESS_SIZE'('h10);
  localparam logic [ADDRESS_SIZE-1:0] SOURCE_MAC_ADDR_2 = ADDRESS_SIZE'('h11);
  localparam logic [ADDRESS_SIZE-1:0] DEST_MAC_ADDR_1   = ADDRESS_SIZE'('h12);
  localparam logic [ADDRESS_SIZE-1:0] DEST_MAC_ADDR_2   = ADDRESS_SIZE'('h13);

  localparam int unsigned MAC_CFG_NUM_REGS = 4;

  typedef enum logic [2:0] {
    MAC_CFG_IDLE,
    MAC_CFG_WR,
    MAC_CFG_RD_REQ,
    MAC_CFG_RD_WAIT,
    MAC_CFG_FINISH
  } mac_cfg_state_t;

endpackage

// File: rtl/mac_config_master.sv
// Avalon-MM initiator that writes the source/destination MAC registers of the
// AES register slave, optionally reads them back and checks them.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   start, src_mac, dst_mac   one-cycle request with the MACs to program
//   mm_*                      Avalon-MM initiator port to the register slave
//   busy, done                sequence in progress / one-cycle end pulse
//   error, err_index,         sticky failure flag, failing register index and
//   err_timeout               cause (1 = timeout, 0 = data mismatch)
module mac_config_master
  import aes_top_pack::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          VERIFY         = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [MAC_ADDR_WIDTH-1:0] src_mac,
  input  logic [MAC_ADDR_WIDTH-1:0] dst_mac,
  output logic [ADDRESS_SIZE-1:0]   mm_address,
  output logic [REG_SIZE-1:0]       mm_writedata,
  output logic                      mm_write,
  output logic                      mm_read,
  input  logic [REG_SIZE-1:0]       mm_readdata,
  input  logic                      mm_readdatavalid,
  input  logic                      mm_waitrequest,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic [1:0]                err_index,
  output logic                      err_timeout
);

  localparam int unsigned IDX_W   = $clog2(MAC_CFG_NUM_REGS);
  localparam int unsigned CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned UPPER_W = MAC_ADDR_WIDTH - REG_SIZE;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(MAC_CFG_NUM_REGS - 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  mac_cfg_state_t            state;
  logic [IDX_W-1:0]          idx;
  logic [IDX_W-1:0]          idx_nxt;
  logic [CNT_W-1:0]          cnt;
  logic                      cnt_hit;
  logic [MAC_ADDR_WIDTH-1:0] src_q;
  logic [MAC_ADDR_WIDTH-1:0] dst_q;

  // Register index to slave address
  function automatic logic [ADDRESS_SIZE-1:0] reg_addr(input logic [IDX_W-1:0] i);
    case (i)
      IDX_W'(0): return SOURCE_MAC_ADDR_1;
      IDX_W'(1): return SOURCE_MAC_ADDR_2;
      IDX_W'(2): return DEST_MAC_ADDR_1;
      default:   return DEST_MAC_ADDR_2;
    endcase
  endfunction

  // Register index to write data: odd indices carry the low word, even the
  // zero-extended upper bits of the MAC
  function automatic logic [REG_SIZE-1:0] reg_data(input logic [IDX_W-1:0]          i,
                                                   input logic [MAC_ADDR_WIDTH-1:0] s,
                                                   input logic [MAC_ADDR_WIDTH-1:0] d);
    logic [MAC_ADDR_WIDTH-1:0] m;
    m = i[1] ? d : s;
    return i[0] ? m[REG_SIZE-1:0] : REG_SIZE'(m[MAC_ADDR_WIDTH-1:REG_SIZE]);
  endfunction

  // Upper registers only hold UPPER_W meaningful bits; the rest is don't-care
  function automatic logic reg_match(input logic [IDX_W-1:0]    i,
                                     input logic [REG_SIZE-1:0] got,
                                     input logic [REG_SIZE-1:0] exp);
    logic [REG_SIZE-1:0] mask;
    mask = i[0] ? '1 : REG_SIZE'({UPPER_W{1'b1}});
    return ((got ^ exp) & mask) == '0;
  endfunction

  assign idx_nxt = idx + IDX_W'(1);
  assign cnt_hit = (cnt == CNT_LIMIT);

  // Sequencer; every exit to FINISH drops the command and pulses done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= MAC_CFG_IDLE;
      idx          <= '0;
      cnt          <= '0;
      src_q        <= '0;
      dst_q        <= '0;
      mm_address   <= '0;
      mm_writedata <= '0;
      mm_write     <= 1'b0;
      mm_read      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      err_index    <= '0;
      err_timeout  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        MAC_CFG_IDLE: begin
          if (start) begin
            src_q        <= src_mac;
            dst_q        <= dst_mac;
            error        <= 1'b0;
            err_index    <= '0;
            err_timeout  <= 1'b0;
            idx          <= '0;
            cnt          <= '0;
            busy         <= 1'b1;
            mm_write     <= 1'b1;
            mm_address   <= reg_addr('0);
            mm_writedata <= reg_data('0, src_mac, dst_mac);
            state        <= MAC_CFG_WR;
          end
        end

        MAC_CFG_WR: begin
          if (!mm_waitrequest) begin
            cnt <= '0;
            if (idx == LAST_IDX) begin
              mm_write <= 1'b0;
              idx      <= '0;
              if (VERIFY) begin
                mm_read    <= 1'b1;
                mm_address <= reg_addr('0);
                state      <= MAC_CFG_RD_REQ;
              end else begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= MAC_CFG_FINISH;
              end
            end else begin
              idx          <= idx_nxt;
              mm_address   <= reg_addr(idx_nxt);
              mm_writedata <= reg_data(idx_nxt, src_q, dst_q);
            end
          end else if (cnt_hit) begin
            mm_write    <= 1'b0;
            error       <= 1'b1;
            err_index   <= idx;
            err_timeout <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b1;
            state       <= MAC_CFG_FINISH;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        MAC_CFG_RD_REQ: begin
          if (!mm_waitrequest) begin
            cnt     <= '0;
            mm_read <= 1'b0;
            state   <= MAC_CFG_RD_WAIT;
          end else if (cnt_hit) begin
            mm_read     <= 1'b0;
            error       <= 1'b1;
            err_index   <= idx;
            err_timeout <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b1;
            state       <= MAC_CFG_FINISH;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        MAC_CFG_RD_WAIT: begin
          if (mm_readdatavalid) begin
            cnt <= '0;
            if (!reg_match(idx, mm_readdata, reg_data(idx, src_q, dst_q))) begin
              error       <= 1'b1;
              err_index   <= idx;
              err_timeout <= 1'b0;
              busy        <= 1'b0;
              done        <= 1'b1;
              state       <= MAC_CFG_FINISH;
            end else if (idx == LAST_IDX) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= MAC_CFG_FINISH;
            end else begin
              idx        <= idx_nxt;
              mm_read    <= 1'b1;
              mm_address <= reg_addr(idx_nxt);
              state      <= MAC_CFG_RD_REQ;
            end
          end else if (cnt_hit) begin
            error       <= 1'b1;
            err_index   <= idx;
            err_timeout <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b1;
            state       <= MAC_CFG_FINISH;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        MAC_CFG_FINISH: state <= MAC_CFG_IDLE;

        default: state <= MAC_CFG_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_config_master.sv
// Scoreboard bench for mac_config_master: stimulus pushes expected bus events
// and done results; a negedge monitor pops and compares as the DUT emits them.
module tb_mac_config_master;

  localparam int KIND_WR   = 0;
  localparam int KIND_RD   = 1;
  localparam int KIND_DONE = 2;

  typedef struct {
    int          kind;
    logic [7:0]  addr;
    logic [31:0] data;
    int          cyc;
    logic        err;
    logic [1:0]  eidx;
    logic        eto;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        start_nv = 1'b0;
  logic [47:0] src_mac = '0;
  logic [47:0] dst_mac = '0;

  logic [7:0]  mm_address;
  logic [31:0] mm_writedata;
  logic        mm_write, mm_read;
  logic [31:0] mm_readdata;
  logic        mm_readdatavalid;
  logic        mm_waitrequest;
  logic        busy, done, error, err_timeout;
  logic [1:0]  err_index;

  logic [7:0]  mm_address_nv;
  logic [31:0] mm_writedata_nv;
  logic        mm_write_nv, mm_read_nv;
  logic        busy_nv, done_nv, error_nv, err_timeout_nv;
  logic [1:0]  err_index_nv;
  logic [31:0] zero32 = '0;
  logic        zero1 = 1'b0;

  int cyc = 0;
  int n_vec = 0;
  int n_fail = 0;
  exp_t sb_q[$];

  // Slave model state
  int          stall_n = 0;
  int          wait_cnt = 0;
  logic [8:0]  hang_addr = 9'h100;
  logic [31:0] mem [0:255];
  logic        ovr_en [0:255];
  logic [31:0] ovr_val [0:255];

  logic [3:0][31:0] vec_a;
  logic [3:0][31:0] vec_b;
  logic [47:0] src_a = 48'hA1B2_C3D4_E5F6;
  logic [47:0] dst_a = 48'h0102_0304_0506;
  logic [47:0] src_b = 48'h0011_2233_4455;
  logic [47:0] dst_b = 48'hFFEE_DDCC_BBAA;

  mac_config_master #(.TIMEOUT_CYCLES(15), .VERIFY(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .src_mac(src_mac), .dst_mac(dst_mac),
    .mm_address(mm_address), .mm_writedata(mm_writedata), .mm_write(mm_write),
    .mm_read(mm_read), .mm_readdata(mm_readdata), .mm_readdatavalid(mm_readdatavalid),
    .mm_waitrequest(mm_waitrequest), .busy(busy), .done(done), .error(error),
    .err_index(err_index), .err_timeout(err_timeout)
  );

  mac_config_master #(.TIMEOUT_CYCLES(15), .VERIFY(1'b0)) dut_nv (
    .clk(clk), .rst(rst), .start(start_nv), .src_mac(src_mac), .dst_mac(dst_mac),
    .mm_address(mm_address_nv), .mm_writedata(mm_writedata_nv), .mm_write(mm_write_nv),
    .mm_read(mm_read_nv), .mm_readdata(zero32), .mm_readdatavalid(zero1),
    .mm_waitrequest(zero1), .busy(busy_nv), .done(done_nv), .error(error_nv),
    .err_index(err_index_nv), .err_timeout(err_timeout_nv)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave: programmable stall per command, read latency 1, optional overrides
  assign mm_waitrequest = (mm_write || mm_read) && (wait_cnt < stall_n);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt         <= 0;
      mm_readdatavalid <= 1'b0;
      mm_readdata      <= '0;
    end else begin
      mm_readdatavalid <= 1'b0;
      if (mm_write || mm_read) wait_cnt <= mm_waitrequest ? wait_cnt + 1 : 0;
      if (mm_write && !mm_waitrequest) mem[mm_address] <= mm_writedata;
      if (mm_read && !mm_waitrequest && ({1'b0, mm_address} != hang_addr)) begin
        mm_readdatavalid <= 1'b1;
        mm_readdata      <= ovr_en[mm_address] ? ovr_val[mm_address] : mem[mm_address];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic flag(input string nm);
    n_vec++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // Monitor: pops one expectation per accepted command or done pulse
  logic        prev_hold = 1'b0;
  logic [7:0]  prev_addr;
  logic [31:0] prev_data;
  logic        prev_wr, prev_rd;
  exp_t        e;

  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("stall_addr", 32'(mm_address), 32'(prev_addr));
        chk("stall_data", mm_writedata, prev_data);
        chk("stall_cmd", {30'b0, mm_write, mm_read}, {30'b0, prev_wr, prev_rd});
      end
      prev_hold = (mm_write || mm_read) && mm_waitrequest;
      prev_addr = mm_address;
      prev_data = mm_writedata;
      prev_wr   = mm_write;
      prev_rd   = mm_read;

      if (mm_write && !mm_waitrequest) begin
        if (sb_q.size() == 0) flag("unexpected_write");
        else begin
          e = sb_q.pop_front();
          chk("wr_kind", 32'(e.kind == KIND_WR), 32'd1);
          chk("wr_addr", 32'(mm_address), 32'(e.addr));
          chk("wr_data", mm_writedata, e.data);
        end
      end
      if (mm_read && !mm_waitrequest) begin
        if (sb_q.size() == 0) flag("unexpected_read");
        else begin
          e = sb_q.pop_front();
          chk("rd_kind", 32'(e.kind == KIND_RD), 32'd1);
          chk("rd_addr", 32'(mm_address), 32'(e.addr));
        end
      end
      if (done) begin
        if (sb_q.size() == 0) flag("unexpected_done");
        else begin
          e = sb_q.pop_front();
          chk("done_kind", 32'(e.kind == KIND_DONE), 32'd1);
          chk("done_cycle", 32'(cyc), 32'(e.cyc));
          chk("done_error", 32'(error), 32'(e.err));
          chk("done_err_index", 32'(err_index), 32'(e.eidx));
          chk("done_err_timeout", 32'(err_timeout), 32'(e.eto));
          chk("done_busy_low", 32'(busy), 32'd0);
          chk("done_cmd_low", {30'b0, mm_write, mm_read}, 32'd0);
        end
      end
    end
  end

  task automatic push_seq(input logic [3:0][31:0] w, input int nwr, input int nrd,
                          input int dcyc, input logic er, input logic [1:0] ei,
                          input logic eto, input int t0);
    exp_t x;
    logic [7:0] a [4];
    a[0] = 8'h10; a[1] = 8'h11; a[2] = 8'h12; a[3] = 8'h13;
    for (int i = 0; i < nwr; i++) begin
      x = '{kind: KIND_WR, addr: a[i], data: w[i], cyc: 0, err: 1'b0, eidx: 2'd0, eto: 1'b0};
      sb_q.push_back(x);
    end
    for (int i = 0; i < nrd; i++) begin
      x = '{kind: KIND_RD, addr: a[i], data: 32'h0, cyc: 0, err: 1'b0, eidx: 2'd0, eto: 1'b0};
      sb_q.push_back(x);
    end
    if (dcyc > 0) begin
      x = '{kind: KIND_DONE, addr: 8'h0, data: 32'h0, cyc: t0 + dcyc, err: er, eidx: ei, eto: eto};
      sb_q.push_back(x);
    end
  endtask

  task automatic drain(input int budget);
    for (int k = 0; k < budget && sb_q.size() != 0; k++) @(negedge clk);
    if (sb_q.size() != 0) begin
      flag("drain_timeout");
      sb_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // Called at a negedge; start is sampled at the following posedge (edge 0)
  task automatic run_seq(input logic [47:0] s, input logic [47:0] d,
                         input logic [3:0][31:0] w, input int nrd, input int dcyc,
                         input logic er, input logic [1:0] ei, input logic eto,
                         input int restart_at);
    int t0;
    t0 = cyc;
    push_seq(w, 4, nrd, dcyc, er, ei, eto, t0);
    src_mac = s;
    dst_mac = d;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_cycle1", 32'(busy), 32'd1);
    chk("error_cleared_on_start", 32'(error), 32'd0);
    if (restart_at > 0) begin
      while (cyc < t0 + restart_at) @(negedge clk);
      src_mac = 48'h1111_2222_3333;
      dst_mac = 48'h4444_5555_6666;
      start   = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    drain(200);
  endtask

  initial begin
    int t0, nwr_nv, nrd_nv, dc;
    logic got;

    vec_a = {32'h0304_0506, 32'h0000_0102, 32'hC3D4_E5F6, 32'h0000_A1B2};
    vec_b = {32'hDDCC_BBAA, 32'h0000_FFEE, 32'h2233_4455, 32'h0000_0011};
    for (int i = 0; i < 256; i++) begin
      mem[i] = '0;
      ovr_en[i] = 1'b0;
      ovr_val[i] = '0;
    end

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_mm_write", 32'(mm_write), 32'd0);
    chk("rst_mm_read", 32'(mm_read), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_err_timeout", 32'(err_timeout), 32'd0);
    chk("rst_mm_address", 32'(mm_address), 32'd0);
    chk("rst_mm_writedata", mm_writedata, 32'd0);
    chk("rst_err_index", 32'(err_index), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    // Zero-wait slave: done in cycle 13
    run_seq(src_a, dst_a, vec_a, 4, 13, 1'b0, 2'd0, 1'b0, 0);

    // Three stall cycles on every command: done in cycle 37
    stall_n = 3;
    run_seq(src_b, dst_b, vec_b, 4, 37, 1'b0, 2'd0, 1'b0, 0);
    stall_n = 0;

    // DST_1 upper bits garbage passes; DST_2 zero mismatches at index 3
    ovr_en[8'h12] = 1'b1; ovr_val[8'h12] = 32'hFFFF_0102;
    ovr_en[8'h13] = 1'b1; ovr_val[8'h13] = 32'h0000_0000;
    run_seq(src_a, dst_a, vec_a, 4, 13, 1'b1, 2'd3, 1'b0, 0);
    chk("sticky_error", 32'(error), 32'd1);
    chk("sticky_err_index", 32'(err_index), 32'd3);
    chk("sticky_err_timeout", 32'(err_timeout), 32'd0);
    ovr_en[8'h12] = 1'b0;
    ovr_en[8'h13] = 1'b0;

    // Read of index 1 never returns: RD_WAIT entered cycle 8, done cycle 23
    hang_addr = 9'h011;
    run_seq(src_b, dst_b, vec_b, 2, 23, 1'b1, 2'd1, 1'b1, 0);
    hang_addr = 9'h100;

    // Second start in cycle 3 with other MACs is ignored
    run_seq(src_b, dst_b, vec_b, 4, 13, 1'b0, 2'd0, 1'b0, 3);

    // Start during the done cycle is ignored; the next cycle it is accepted
    t0 = cyc;
    push_seq(vec_a, 4, 4, 13, 1'b0, 2'd0, 1'b0, t0);
    src_mac = src_a; dst_mac = dst_a; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < t0 + 13) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    chk("start_in_done_ignored", 32'(busy), 32'd0);
    t0 = cyc;
    push_seq(vec_b, 4, 4, 13, 1'b0, 2'd0, 1'b0, t0);
    src_mac = src_b; dst_mac = dst_b;
    @(negedge clk);
    start = 1'b0;
    chk("start_after_done_accepted", 32'(busy), 32'd1);
    drain(200);

    // Reset while writing index 2: command drops without waiting for a clock
    t0 = cyc;
    push_seq(vec_a, 2, 0, 0, 1'b0, 2'd0, 1'b0, t0);
    src_mac = src_a; dst_mac = dst_a; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_mm_write", 32'(mm_write), 32'd0);
    chk("rst_async_busy", 32'(busy), 32'd0);
    chk("rst_async_address", 32'(mm_address), 32'd0);
    chk("rst_pending_events", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // VERIFY=0 instance: done in cycle 5, four writes, no reads
    t0 = cyc;
    nwr_nv = 0; nrd_nv = 0; got = 1'b0; dc = 0;
    start_nv = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      start_nv = 1'b0;
      if (mm_write_nv) nwr_nv++;
      if (mm_read_nv) nrd_nv++;
      if (done_nv) begin
        got = 1'b1;
        dc  = cyc;
        break;
      end
    end
    if (!got) flag("nv_done_timeout");
    else begin
      chk("nv_done_cycle", 32'(dc), 32'(t0 + 5));
      chk("nv_error", 32'(error_nv), 32'd0);
      chk("nv_busy_in_done", 32'(busy_nv), 32'd0);
      chk("nv_write_count", 32'(nwr_nv), 32'd4);
      chk("nv_read_count", 32'(nrd_nv), 32'd0);
      chk("nv_last_addr", 32'(mm_address_nv), 32'h13);
      chk("nv_last_data", mm_writedata_nv, 32'h0304_0506);
    end
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_watchdog (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
